// File: rtl/riscv_structures.sv
// rtl/riscv_structures.sv - shared write-back request type, channel enum and register-file constants
package riscv_structures;

  localparam int WB_XLEN   = 32;
  localparam int REG_COUNT = 32;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    CH_LD  = 1'b0,
    CH_MUL = 1'b1
  } wb_ch_e;

  // One-hot register mask; x0 never tracks a pending write.
  function automatic logic [REG_COUNT-1:0] rd_mask(input logic [4:0] rd);
    logic [REG_COUNT-1:0] m;
    m = '0;
    if (rd != 5'd0) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry synchronous FIFO of write-back requests, no pass-through
module wb_fifo
  import riscv_structures::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full is decided by occupancy alone, so a pop never frees a slot in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU, load and multiplier results onto the register-file write port
module wb_arbiter
  import riscv_structures::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [4:0]           alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [4:0]           ld_rd,
  input  logic [XLEN-1:0]      ld_data,
  input  logic                 mul_valid,
  output logic                 mul_ready,
  input  logic [4:0]           mul_rd,
  input  logic [XLEN-1:0]      mul_data,
  output logic [4:0]           a3,
  output logic                 we3,
  output logic [XLEN-1:0]      wd,
  output logic [REG_COUNT-1:0] busy
);

  wb_req_t                ld_req;
  wb_req_t                mul_req;
  wb_req_t                ld_head;
  wb_req_t                mul_head;
  logic                   ld_full;
  logic                   ld_empty;
  logic                   mul_full;
  logic                   mul_empty;
  logic [$clog2(DEPTH):0] ld_count;
  logic [$clog2(DEPTH):0] mul_count;
  logic                   ld_pop;
  logic                   mul_pop;
  wb_ch_e                 ptr;
  logic [REG_COUNT-1:0]   busy_next;

  assign ld_req    = '{rd: ld_rd, data: ld_data};
  assign mul_req   = '{rd: mul_rd, data: mul_data};
  assign ld_ready  = !ld_full;
  assign mul_ready = !mul_full;

  wb_fifo #(.DEPTH(DEPTH)) u_ld_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ld_valid),
    .push_data (ld_req),
    .pop       (ld_pop),
    .head      (ld_head),
    .full      (ld_full),
    .empty     (ld_empty),
    .count     (ld_count)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mul_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mul_valid),
    .push_data (mul_req),
    .pop       (mul_pop),
    .head      (mul_head),
    .full      (mul_full),
    .empty     (mul_empty),
    .count     (mul_count)
  );

  // ALU owns the port whenever it has a result; buffered heads share the rest round-robin.
  always_comb begin
    ld_pop  = 1'b0;
    mul_pop = 1'b0;
    if (!alu_valid) begin
      if (!ld_empty && (mul_empty || ptr == CH_LD)) ld_pop = 1'b1;
      else if (!mul_empty)                          mul_pop = 1'b1;
    end
  end

  always_comb begin
    busy_next = busy;
    if (we3)                   busy_next &= ~rd_mask(a3);
    if (alu_valid)             busy_next |= rd_mask(alu_rd);
    if (ld_valid && ld_ready)  busy_next |= rd_mask(ld_rd);
    if (mul_valid && mul_ready) busy_next |= rd_mask(mul_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a3   <= '0;
      we3  <= 1'b0;
      wd   <= '0;
      busy <= '0;
      ptr  <= CH_LD;
    end else begin
      busy <= busy_next;
      we3  <= 1'b0;
      if (alu_valid) begin
        if (alu_rd != 5'd0) begin
          we3 <= 1'b1;
          a3  <= alu_rd;
          wd  <= alu_data;
        end
      end else if (ld_pop) begin
        ptr <= CH_MUL;
        if (ld_head.rd != 5'd0) begin
          we3 <= 1'b1;
          a3  <= ld_head.rd;
          wd  <= ld_head.data;
        end
      end else if (mul_pop) begin
        ptr <= CH_LD;
        if (mul_head.rd != 5'd0) begin
          we3 <= 1'b1;
          a3  <= mul_head.rd;
          wd  <= mul_head.data;
        end
      end
    end
  end

  // Producer protocol: no destination already pending, no destination shared within a cycle.
  assert property (@(posedge clk) disable iff (rst)
    (alu_valid && alu_rd != 5'd0) |-> !busy[alu_rd]);
  assert property (@(posedge clk) disable iff (rst)
    (ld_valid && ld_rd != 5'd0) |-> !busy[ld_rd]);
  assert property (@(posedge clk) disable iff (rst)
    (mul_valid && mul_rd != 5'd0) |-> !busy[mul_rd]);
  assert property (@(posedge clk) disable iff (rst)
    !(alu_valid && ld_valid && alu_rd != 5'd0 && alu_rd == ld_rd));
  assert property (@(posedge clk) disable iff (rst)
    !(alu_valid && mul_valid && alu_rd != 5'd0 && alu_rd == mul_rd));
  assert property (@(posedge clk) disable iff (rst)
    !(ld_valid && mul_valid && ld_rd != 5'd0 && ld_rd == mul_rd));
  assert property (@(posedge clk) disable iff (rst)
    (ld_count <= ($clog2(DEPTH)+1)'(DEPTH)) && (mul_count <= ($clog2(DEPTH)+1)'(DEPTH)));

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int BIG   = 1 << 30;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, ld_valid, mul_valid;
  logic [4:0]      alu_rd, ld_rd, mul_rd;
  logic [XLEN-1:0] alu_data, ld_data, mul_data;
  logic            ld_ready, mul_ready;
  logic [4:0]      a3;
  logic            we3;
  logic [XLEN-1:0] wd;
  logic [31:0]     busy;

  wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_rd(mul_rd), .mul_data(mul_data),
    .a3(a3), .we3(we3), .wd(wd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; int due; } exp_t;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  ent_t ldq[$];
  ent_t mulq[$];
  exp_t expq[$];
  bit   next_mul;
  bit   ld_hold, mul_hold;
  int   pend_from[32];
  int   pend_until[32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_busy(input int c);
    logic [31:0] m = '0;
    for (int r = 1; r < 32; r++)
      if (pend_from[r] <= c && c <= pend_until[r]) m[r] = 1'b1;
    return m;
  endfunction

  function automatic logic [4:0] pick_rd(input int c, input logic [4:0] x1, input logic [4:0] x2);
    for (int t = 0; t < 40; t++) begin
      logic [4:0] r = 5'($urandom_range(1, 31));
      if (pend_until[r] < c && r != x1 && r != x2) return r;
    end
    return 5'd0;
  endfunction

  task automatic model_clear();
    ldq.delete();
    mulq.delete();
    expq.delete();
    next_mul = 1'b0;
    ld_hold  = 1'b0;
    mul_hold = 1'b0;
    for (int r = 0; r < 32; r++) begin
      pend_from[r]  = BIG;
      pend_until[r] = -1;
    end
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] data, input int due);
    exp_t e;
    e.rd = rd; e.data = data; e.due = due;
    expq.push_back(e);
    pend_until[rd] = due;
  endtask

  // Predicts the effect of the coming clock edge from the inputs currently driven.
  task automatic model_step();
    int   n = cyc;
    bit   ld_ok = ldq.size() < DEPTH;
    bit   mul_ok = mulq.size() < DEPTH;
    ent_t e;
    if (alu_valid) begin
      if (alu_rd != 5'd0) begin
        pend_from[alu_rd] = n + 1;
        expect_write(alu_rd, alu_data, n + 1);
      end
    end else if (ldq.size() > 0 || mulq.size() > 0) begin
      if (ldq.size() > 0 && (mulq.size() == 0 || !next_mul)) begin
        e = ldq.pop_front(); next_mul = 1'b1;
      end else begin
        e = mulq.pop_front(); next_mul = 1'b0;
      end
      if (e.rd != 5'd0) expect_write(e.rd, e.data, n + 1);
    end
    if (ld_valid && ld_ok) begin
      e.rd = ld_rd; e.data = ld_data; ldq.push_back(e);
      if (ld_rd != 5'd0) begin pend_from[ld_rd] = n + 1; pend_until[ld_rd] = BIG; end
    end
    if (mul_valid && mul_ok) begin
      e.rd = mul_rd; e.data = mul_data; mulq.push_back(e);
      if (mul_rd != 5'd0) begin pend_from[mul_rd] = n + 1; pend_until[mul_rd] = BIG; end
    end
    ld_hold  = ld_valid && !ld_ok;
    mul_hold = mul_valid && !mul_ok;
  endtask

  task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ldd,
                       input bit mv, input logic [4:0] mr, input logic [31:0] md);
    @(negedge clk);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid = lv; ld_rd = lr; ld_data = ldd;
    mul_valid = mv; mul_rd = mr; mul_data = md;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alu_valid = 1'b0; ld_valid = 1'b0; mul_valid = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    model_step();
  endtask

  task automatic rand_cycle(input int p_alu, input int p_ld, input int p_mul);
    @(negedge clk);
    if (!ld_hold) begin
      ld_valid = $urandom_range(0, 99) < p_ld;
      ld_data  = $urandom;
      ld_rd    = 5'd0;
    end
    if (!mul_hold) begin
      mul_valid = $urandom_range(0, 99) < p_mul;
      mul_data  = $urandom;
      mul_rd    = 5'd0;
    end
    if (!ld_hold && ld_valid && $urandom_range(0, 9) != 0)
      ld_rd = pick_rd(cyc, mul_valid ? mul_rd : 5'd0, 5'd0);
    if (!mul_hold && mul_valid && $urandom_range(0, 9) != 0)
      mul_rd = pick_rd(cyc, ld_valid ? ld_rd : 5'd0, 5'd0);
    alu_valid = $urandom_range(0, 99) < p_alu;
    alu_data  = $urandom;
    alu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 :
                pick_rd(cyc, ld_valid ? ld_rd : 5'd0, mul_valid ? mul_rd : 5'd0);
    model_step();
  endtask

  // Monitor: samples just after each rising edge and retires expected writes in order.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk(ld_ready === (ldq.size() < DEPTH), "ld_ready", ld_ready, ldq.size() < DEPTH);
        chk(mul_ready === (mulq.size() < DEPTH), "mul_ready", mul_ready, mulq.size() < DEPTH);
        chk(busy === exp_busy(cyc), "busy", busy, exp_busy(cyc));
        if (we3 === 1'b1) begin
          chk(expq.size() > 0, "write_expected", a3, 0);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk(a3 === e.rd, "a3", a3, e.rd);
            chk(wd === e.data, "wd", wd, e.data);
            chk(cyc == e.due, "latency", cyc, e.due);
          end
        end else if (expq.size() > 0 && expq[0].due <= cyc) begin
          e = expq.pop_front();
          chk(we3 === 1'b1, "write_missing", we3, 1);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    mul_valid = 0; mul_rd = 0; mul_data = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    model_step();
    idle(10);

    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    idle(3);

    drive(0, 0, 0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    idle(4);

    for (int i = 0; i < 4; i++)
      drive(1, pick_rd(cyc, 5'(20 + i), 0), $urandom, 1, 5'(20 + i), 32'h100 + i, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      drive(1, pick_rd(cyc, 0, 0), $urandom, 0, 0, 0, 0, 0, 0);
    idle(6);

    drive(1, 5'd0, 32'h5, 1, 5'd0, 32'h77, 0, 0, 0);
    idle(4);

    drive(1, 5'd9,  32'hA9, 1, 5'd6, 32'h66, 0, 0, 0);
    drive(1, 5'd10, 32'hAA, 1, 5'd7, 32'h67, 0, 0, 0);
    drive(1, 5'd11, 32'hAB, 1, 5'd8, 32'h68, 0, 0, 0);
    do_reset();
    idle(6);

    for (int i = 0; i < 300; i++) rand_cycle(40, 50, 50);
    do_reset();
    for (int i = 0; i < 200; i++) rand_cycle(10, 70, 70);
    for (int i = 0; i < 200; i++) rand_cycle(80, 60, 60);

    for (int i = 0; i < 100 && (expq.size() > 0 || ldq.size() > 0 || mulq.size() > 0); i++)
      idle(1);
    idle(3);
    chk(expq.size() == 0 && ldq.size() == 0 && mulq.size() == 0, "drain",
        expq.size() + ldq.size() + mulq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
